// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate enable, x/y counters, registered
// sync/blanking aligned with x/y, and a once-per-frame tick plus frame counter.
module vga_timing_gen #(
    parameter int   H_DISPLAY   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_DISPLAY   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter int   CLK_DIV     = 4,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   TICK_LINE   = V_DISPLAY + 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        p_tick,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_tick,
    output logic [15:0] frame_count
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [9:0] TICK_Y   = 10'(TICK_LINE);
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0]  div_cnt_q, div_cnt_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic        video_on_q, video_on_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        frame_tick_q, frame_tick_d;
    logic [15:0] frame_count_q, frame_count_d;

    // With CLK_DIV=1 the divider sits at 0 == DIV_LAST, so p_tick stays high.
    assign p_tick = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? 4'd0 : div_cnt_q + 4'd1;
        x_d       = x_q;
        y_d       = y_q;
        if (p_tick) begin
            if (x_q == H_LAST) begin
                x_d = 10'd0;
                y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end

        // Decoded from next-state position so outputs line up with x/y.
        video_on_d = (x_d < H_VIS) && (y_d < V_VIS);
        hsync_d    = (x_d >= HS_START && x_d < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d    = (y_d >= VS_START && y_d < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

        // Only the edge that enters (0, TICK_LINE) fires, not the dwell clocks.
        frame_tick_d  = p_tick && (x_q == H_LAST) && (y_d == TICK_Y);
        frame_count_d = frame_tick_d ? frame_count_q + 16'd1 : frame_count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q     <= 4'd0;
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            video_on_q    <= 1'b1;
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            frame_tick_q  <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_tick_q  <= frame_tick_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign video_on    = video_on_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_tick  = frame_tick_q;
    assign frame_count = frame_count_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing for the first lines, plus two shrunken
// rasters (CLK_DIV=4 and CLK_DIV=1) to cover vertical timing and frame ticks.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt;

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset)
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;

    logic        pt_a, vo_a, hs_a, vs_a, ft_a;
    logic [9:0]  x_a, y_a;
    logic [15:0] fc_a;
    logic        pt_b, vo_b, hs_b, vs_b, ft_b;
    logic [9:0]  x_b, y_b;
    logic [15:0] fc_b;
    logic        pt_c, vo_c, hs_c, vs_c, ft_c;
    logic [9:0]  x_c, y_c;
    logic [15:0] fc_c;

    vga_timing_gen dut_a (
        .clk(clk), .reset(reset), .p_tick(pt_a), .x(x_a), .y(y_a),
        .video_on(vo_a), .hsync(hs_a), .vsync(vs_a),
        .frame_tick(ft_a), .frame_count(fc_a)
    );

    // 16x10 total raster: visible 8x6, hsync x 10..12, vsync y 7..8, tick line 7.
    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .CLK_DIV(4)
    ) dut_b (
        .clk(clk), .reset(reset), .p_tick(pt_b), .x(x_b), .y(y_b),
        .video_on(vo_b), .hsync(hs_b), .vsync(vs_b),
        .frame_tick(ft_b), .frame_count(fc_b)
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .CLK_DIV(1)
    ) dut_c (
        .clk(clk), .reset(reset), .p_tick(pt_c), .x(x_c), .y(y_c),
        .video_on(vo_c), .hsync(hs_c), .vsync(vs_c),
        .frame_tick(ft_c), .frame_count(fc_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_edge(input int n);
        while (edge_cnt < n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("c_ptick_in_reset", 32'(pt_c), 32'd1);
        reset = 1'b0;
        wait_edge(50);
        chk("a_x_before_reset", 32'(x_a), 32'd12);

        // Reset asserted mid-count, between clock edges.
        #2 reset = 1'b1;
        #1;
        chk("a_x_async_reset", 32'(x_a), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("a_x_reset", 32'(x_a), 32'd0);
        chk("a_y_reset", 32'(y_a), 32'd0);
        chk("a_vo_reset", 32'(vo_a), 32'd1);
        chk("a_hs_reset", 32'(hs_a), 32'd1);
        chk("a_vs_reset", 32'(vs_a), 32'd1);
        chk("a_ft_reset", 32'(ft_a), 32'd0);
        chk("a_fc_reset", 32'(fc_a), 32'd0);
        chk("a_pt_reset", 32'(pt_a), 32'd0);
        chk("c_pt_reset", 32'(pt_c), 32'd1);
        reset = 1'b0;

        for (int n = 0; n <= 40; n++) begin
            wait_edge(n);
            chk($sformatf("a_ptick_e%0d", n), 32'(pt_a), 32'((n % 4) == 3));
            if (n == 3) chk("a_x_e3", 32'(x_a), 32'd0);
            if (n == 4) chk("a_x_e4", 32'(x_a), 32'd1);
            if (n <= 20) begin
                chk($sformatf("c_x_e%0d", n), 32'(x_c), 32'(n % 16));
                chk($sformatf("c_pt_e%0d", n), 32'(pt_c), 32'd1);
            end
        end
        chk("a_x_e40", 32'(x_a), 32'd10);

        wait_edge(111); chk("c_ft_e111", 32'(ft_c), 32'd0);
        wait_edge(112); chk("c_ft_e112", 32'(ft_c), 32'd1);
                        chk("c_fc_e112", 32'(fc_c), 32'd1);
                        chk("c_y_e112", 32'(y_c), 32'd7);
        wait_edge(113); chk("c_ft_e113", 32'(ft_c), 32'd0);
        wait_edge(160); chk("c_x_e160", 32'(x_c), 32'd0);
                        chk("c_y_e160", 32'(y_c), 32'd0);
        wait_edge(271); chk("c_ft_e271", 32'(ft_c), 32'd0);
        wait_edge(272); chk("c_ft_e272", 32'(ft_c), 32'd1);
                        chk("c_fc_e272", 32'(fc_c), 32'd2);
        wait_edge(273); chk("c_ft_e273", 32'(ft_c), 32'd0);

        wait_edge(447); chk("b_y_e447", 32'(y_b), 32'd6);
                        chk("b_vs_e447", 32'(vs_b), 32'd1);
                        chk("b_ft_e447", 32'(ft_b), 32'd0);
                        chk("b_fc_e447", 32'(fc_b), 32'd0);
        wait_edge(448); chk("b_y_e448", 32'(y_b), 32'd7);
                        chk("b_x_e448", 32'(x_b), 32'd0);
                        chk("b_vs_e448", 32'(vs_b), 32'd0);
                        chk("b_vo_e448", 32'(vo_b), 32'd0);
                        chk("b_ft_e448", 32'(ft_b), 32'd1);
                        chk("b_fc_e448", 32'(fc_b), 32'd1);
        wait_edge(449); chk("b_ft_e449", 32'(ft_b), 32'd0);
                        chk("b_fc_e449", 32'(fc_b), 32'd1);
        wait_edge(451); chk("b_ft_e451", 32'(ft_b), 32'd0);
        wait_edge(575); chk("b_vs_e575", 32'(vs_b), 32'd0);
        wait_edge(576); chk("b_vs_e576", 32'(vs_b), 32'd1);
                        chk("b_y_e576", 32'(y_b), 32'd9);
        wait_edge(640); chk("b_x_e640", 32'(x_b), 32'd0);
                        chk("b_y_e640", 32'(y_b), 32'd0);
                        chk("b_vo_e640", 32'(vo_b), 32'd1);
        wait_edge(1087); chk("b_ft_e1087", 32'(ft_b), 32'd0);
        wait_edge(1088); chk("b_ft_e1088", 32'(ft_b), 32'd1);
                         chk("b_fc_e1088", 32'(fc_b), 32'd2);
        wait_edge(1089); chk("b_ft_e1089", 32'(ft_b), 32'd0);

        wait_edge(2559); chk("a_vo_e2559", 32'(vo_a), 32'd1);
                         chk("a_x_e2559", 32'(x_a), 32'd639);
        wait_edge(2560); chk("a_vo_e2560", 32'(vo_a), 32'd0);
                         chk("a_x_e2560", 32'(x_a), 32'd640);
        wait_edge(2623); chk("a_hs_e2623", 32'(hs_a), 32'd1);
        wait_edge(2624); chk("a_hs_e2624", 32'(hs_a), 32'd0);
                         chk("a_x_e2624", 32'(x_a), 32'd656);
        wait_edge(3007); chk("a_hs_e3007", 32'(hs_a), 32'd0);
        wait_edge(3008); chk("a_hs_e3008", 32'(hs_a), 32'd1);
                         chk("a_x_e3008", 32'(x_a), 32'd752);
        wait_edge(3199); chk("a_x_e3199", 32'(x_a), 32'd799);
                         chk("a_y_e3199", 32'(y_a), 32'd0);
        wait_edge(3200); chk("a_x_e3200", 32'(x_a), 32'd0);
                         chk("a_y_e3200", 32'(y_a), 32'd1);
                         chk("a_vo_e3200", 32'(vo_a), 32'd1);
                         chk("a_vs_e3200", 32'(vs_a), 32'd1);
                         chk("a_fc_e3200", 32'(fc_a), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 100 MHz system clock.
- Sits directly upstream of the pixel generator and supplies its x, y and video_on inputs.
- Drives hsync/vsync to the VGA connector.
- Adds a single-clock frame_tick and a frame counter so game logic updates exactly once per frame. A raster-position decode would stay true for CLK_DIV clocks.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
CLK_DIV, 4, clk cycles per pixel; legal range 1..16
SYNC_ACTIVE, 0, logic level of hsync/vsync during the sync pulse
TICK_LINE, V_DISPLAY+1, line on which frame_tick fires

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-high
p_tick  out  1  pixel enable; one clk high every CLK_DIV clks
x  out  10  current pixel column, 0..H_TOTAL-1
y  out  10  current line, 0..V_TOTAL-1
video_on  out  1  high when x<H_DISPLAY and y<V_DISPLAY
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
frame_tick  out  1  one-clk pulse per frame
frame_count  out  16  frames since reset, wraps

Behaviour:
- Reset is asynchronous, active-high, on clock clk.
- Derived constants:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK, default 800.
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK, default 525.
- Reset values:
  - div_cnt=0, x=0, y=0, video_on=1.
  - hsync=vsync=~SYNC_ACTIVE.
  - frame_tick=0, frame_count=0.
  - p_tick=0, or 1 when CLK_DIV=1.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - p_tick = (div_cnt==CLK_DIV-1), combinational from the register.
  - CLK_DIV=1 holds p_tick high constantly.
- Counters:
  - On a clk edge with p_tick=1, x increments.
  - At x==H_TOTAL-1, x wraps to 0 and y increments.
  - At x==H_TOTAL-1 and y==V_TOTAL-1, both go to 0.
  - Without p_tick, x and y hold.
- Sync and blanking outputs:
  - video_on, hsync and vsync are registers loaded from next-state x/y, so they always match the currently presented x/y. There is no pipeline skew.
  - hsync = SYNC_ACTIVE iff H_DISPLAY+H_FRONT <= x < H_DISPLAY+H_FRONT+H_SYNC (656..751).
  - vsync = SYNC_ACTIVE iff V_DISPLAY+V_FRONT <= y < V_DISPLAY+V_FRONT+V_SYNC (490..491).
- Frame tick and count:
  - frame_tick is a register. It is 1 only in the first clk in which (x,y)==(0,TICK_LINE), i.e. it is loaded on the same edge that moves the counters to that position.
  - It is low in all other cycles, including the remaining CLK_DIV-1 clocks at that position.
  - frame_count increments (mod 2^16) on that same edge.
- Reset mid-frame: all state returns to reset values immediately; the next frame starts at (0,0) after release. No partial-state retention.
- Invalid parameters are unsupported: CLK_DIV=0, or H_TOTAL/V_TOTAL > 1024.
- Latency: x=N, y=0 first appears CLK_DIV*N edges after reset release (N<H_TOTAL).
  - Line period = H_TOTAL*CLK_DIV = 3200 clk.
  - Frame period = 1,680,000 clk.

Test Plan:
- Reset state:
  - Stimulus: assert reset mid-count, hold 3 clk.
  - Required: x=0, y=0, video_on=1, hsync=vsync=1, frame_tick=0, frame_count=0, all while reset is still asserted.
- Pixel cadence:
  - Stimulus: release reset, count edges.
  - Required: p_tick high on every 4th clk; x=1 after edge 4; x=10 after edge 40.
- Horizontal timing:
  - Required: video_on falls when x becomes 640 (edge 2560).
  - Required: hsync low for x 656..751 (edges 2624..3007), then high.
  - Required: x wraps 799->0 and y becomes 1 at edge 3200.
- Vertical timing and frame wrap:
  - Required: vsync low exactly while y is 490..491.
  - Required: at edge 1,680,000, x=0, y=0, video_on=1.
- frame_tick:
  - Required: pulse exactly one clk wide at edge 1,539,200 (x=0, y=481); frame_count becomes 1.
  - Required: next pulse 1,680,000 clk later; frame_count=2.
- CLK_DIV=1 variant:
  - Required: p_tick constantly high; x increments every clk; frame period 420,000 clk; frame_tick still one clk wide.
